// File: rtl/neos2test_led_fader.sv
// -----------------------------------------------------------------------------
// neos2test_led_fader
//
// Purpose:
//   Sits between the 10-bit PIO out_port and the board LEDs. Each LED does not
//   switch hard on or off. Its brightness level ramps one step at a time toward
//   the commanded state (full on or full off), and a per-channel PWM comparator
//   turns that level into the pin drive. A bypass input gives raw direct drive.
//
// Ports:
//   clk         in   1      system clock
//   reset       in   1      asynchronous, active-high reset
//   pattern_in  in   WIDTH  target LED pattern (bit=1 -> fade to full on)
//   bypass      in   1      1 = drive LEDs straight from the registered pattern
//   led_out     out  WIDTH  registered PWM LED drive
//   settled     out  1      registered; 1 when every level equals its target
//
// Timing chain:
//   presc (0..PRESCALE-1)     -> tick once per PRESCALE clocks
//   pwm_cnt (0..MAX) on tick  -> period_end when it wraps
//   step_cnt (0..STEP_PERIODS-1) on period_end -> fade_tick when it wraps
//   Each fade_tick moves every level one step toward its target.
//
// There is no valid/ready handshake on this block. pattern_in is sampled
// every cycle, and led_out/settled are free-running registered outputs.
// -----------------------------------------------------------------------------
module neos2test_led_fader #(
    parameter int WIDTH        = 10,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 195,
    parameter int STEP_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             bypass,
    output logic [WIDTH-1:0] led_out,
    output logic             settled
);

    // Counter widths are kept at least 1 bit wide so PRESCALE=1 or
    // STEP_PERIODS=1 still give a legal, permanently-zero counter.
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int STEP_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PWM_BITS-1:0] MAX        = '1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(STEP_PERIODS - 1);

    logic [WIDTH-1:0]    pat_q;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] level     [WIDTH];

    logic                tick;
    logic                period_end;
    logic                fade_tick;
    logic [PWM_BITS-1:0] target    [WIDTH];
    logic [PWM_BITS-1:0] level_nxt [WIDTH];
    logic [WIDTH-1:0]    led_nxt;
    logic                all_match;

    always_comb begin
        tick       = (presc == PRESC_LAST);
        period_end = tick && (pwm_cnt == MAX);
        fade_tick  = period_end && (step_cnt == STEP_LAST);
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            target[i] = pat_q[i] ? MAX : '0;
        end
    end

    // Next level, next LED drive and the settled compare, per channel.
    // Targets are only ever 0 or MAX, so stepping toward the target can
    // never overshoot: the level saturates at either end by construction.
    always_comb begin
        all_match = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            level_nxt[i] = level[i];
            led_nxt[i]   = (level[i] == MAX) || (level[i] > pwm_cnt);
            if (bypass) begin
                // Snap the level so fading resumes from the displayed
                // state when bypass is released.
                level_nxt[i] = target[i];
                led_nxt[i]   = pat_q[i];
            end else if (fade_tick) begin
                if (level[i] < target[i]) begin
                    level_nxt[i] = level[i] + 1'b1;
                end else if (level[i] > target[i]) begin
                    level_nxt[i] = level[i] - 1'b1;
                end
            end
            if (level[i] != target[i]) begin
                all_match = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q    <= '0;
            presc    <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                level[i] <= '0;
            end
            led_out  <= '0;
            settled  <= 1'b1;
        end else begin
            pat_q <= pattern_in;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (period_end) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
            end
            for (int i = 0; i < WIDTH; i++) begin
                level[i] <= level_nxt[i];
            end
            led_out <= led_nxt;
            settled <= all_match;
        end
    end

endmodule

// File: tb/tb_neos2test_led_fader.sv
// -----------------------------------------------------------------------------
// tb_neos2test_led_fader
//
// Bench for neos2test_led_fader with PWM_BITS=4, PRESCALE=2, STEP_PERIODS=1.
// A tick occurs every 2 clocks, a PWM period is 32 clocks, and one level step
// happens per period. cyc counts clock edges since reset release. After edge
// n the counters are presc=n%2 and pwm_cnt=(n/2)%16, so fade steps land on
// edges where cyc%32==0. A period sampled on the 32 negedges after such an
// edge sees one constant level L, and a channel is high on 2*L of those
// samples (32 at L=15).
// -----------------------------------------------------------------------------
module tb_neos2test_led_fader;

    logic       clk;
    logic       reset;
    logic [9:0] pattern_in;
    logic       bypass;
    logic [9:0] led_out;
    logic       settled;

    int cyc;
    int n_checks;
    int n_fail;

    neos2test_led_fader #(
        .WIDTH       (10),
        .PWM_BITS    (4),
        .PRESCALE    (2),
        .STEP_PERIODS(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pattern_in(pattern_in),
        .bypass    (bypass),
        .led_out   (led_out),
        .settled   (settled)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset      = 1'b1;
        pattern_in = 10'h000;
        bypass     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) until the last edge was a fade-step edge.
    task automatic sync_to(input int r);
        int n;
        n = 0;
        while (((cyc % 32) != r) && (n < 64)) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Sample one 32-cycle PWM period: count highs on channel ch, capture
    // settled on the first two samples, flag any other channel lit.
    task automatic run_period(input int ch, output int cnt, output logic s1,
                              output logic s2, output logic stray);
        logic [9:0] one;
        logic [9:0] others;
        one    = 10'd1;
        others = ~(one << ch);
        cnt    = 0;
        s1     = 1'b0;
        s2     = 1'b0;
        stray  = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 1) s1 = settled;
            if (i == 2) s2 = settled;
            if (led_out[ch]) cnt++;
            if ((led_out & others) != 10'd0) stray = 1'b1;
        end
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        logic bad_led;
        logic bad_set;
        reset      = 1'b1;
        bypass     = 1'b0;
        pattern_in = 10'($urandom_range(1, 1023));
        repeat (3) @(negedge clk);
        n_checks++;
        if (led_out !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_led: got %h expected %h", led_out, 10'h000);
        end
        n_checks++;
        if (settled !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_settled: got %b expected 1", settled);
        end
        pattern_in = 10'h000;
        reset      = 1'b0;
        bad_led = 1'b0;
        bad_set = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (led_out !== 10'h000) bad_led = 1'b1;
            if (settled !== 1'b1) bad_set = 1'b1;
        end
        n_checks++;
        if (bad_led) begin
            n_fail++;
            $display("FAIL post_reset_led: got lit=1 expected lit=0");
        end
        n_checks++;
        if (bad_set) begin
            n_fail++;
            $display("FAIL post_reset_settled: got unsettled=1 expected unsettled=0");
        end
    endtask

    task automatic test_rise();
        int   cnt;
        int   exp_cnt;
        logic s1, s2, stray;
        sync_to(0);
        pattern_in = 10'h001;
        run_period(0, cnt, s1, s2, stray);
        n_checks++;
        if (s1 !== 1'b1 || s2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_settled_drop: got %b%b expected 10", s1, s2);
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL rise_level0: got %0d expected 0", cnt);
        end
        for (int lv = 1; lv <= 16; lv++) begin
            run_period(0, cnt, s1, s2, stray);
            exp_cnt = (lv >= 15) ? 32 : 2 * lv;
            n_checks++;
            if (cnt != exp_cnt) begin
                n_fail++;
                $display("FAIL rise_duty_l%0d: got %0d expected %0d", lv, cnt, exp_cnt);
            end
            n_checks++;
            if (s1 !== (lv >= 15) || stray !== 1'b0) begin
                n_fail++;
                $display("FAIL rise_flags_l%0d: got settled=%b stray=%b expected settled=%b stray=0",
                         lv, s1, stray, (lv >= 15));
            end
        end
    endtask

    task automatic test_hold_level5();
        int   cnt;
        logic s1, s2, stray;
        do_reset();
        sync_to(0);
        pattern_in = 10'h001;
        for (int lv = 0; lv < 5; lv++) begin
            run_period(0, cnt, s1, s2, stray);
        end
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL hold_l4: got %0d expected 8", cnt);
        end
        pattern_in = 10'h000;
        run_period(0, cnt, s1, s2, stray);
        n_checks++;
        if (cnt != 10) begin
            n_fail++;
            $display("FAIL hold_l5_duty: got %0d expected 10", cnt);
        end
        n_checks++;
        if (s2 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_l5_settled: got %b expected 0", s2);
        end
        run_period(0, cnt, s1, s2, stray);
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL hold_reverse_l4: got %0d expected 8", cnt);
        end
    endtask

    task automatic test_fall();
        int   cnt;
        logic s1, s2, stray;
        do_reset();
        sync_to(0);
        pattern_in = 10'h008;
        for (int lv = 0; lv < 8; lv++) begin
            run_period(3, cnt, s1, s2, stray);
        end
        n_checks++;
        if (cnt != 14 || stray !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_rise_l7: got %0d stray=%b expected 14 stray=0", cnt, stray);
        end
        pattern_in = 10'h000;
        for (int j = 0; j <= 8; j++) begin
            run_period(3, cnt, s1, s2, stray);
            n_checks++;
            if (cnt != 2 * (8 - j)) begin
                n_fail++;
                $display("FAIL fall_duty_l%0d: got %0d expected %0d", 8 - j, cnt, 2 * (8 - j));
            end
            n_checks++;
            if (s1 !== (j == 8)) begin
                n_fail++;
                $display("FAIL fall_settled_l%0d: got %b expected %b", 8 - j, s1, (j == 8));
            end
        end
    endtask

    task automatic test_bypass();
        logic bad_led;
        logic bad_set;
        do_reset();
        @(negedge clk);
        bypass     = 1'b1;
        pattern_in = 10'h2AA;
        @(negedge clk);
        n_checks++;
        if (led_out !== 10'h000) begin
            n_fail++;
            $display("FAIL bypass_lat1: got %h expected %h", led_out, 10'h000);
        end
        @(negedge clk);
        n_checks++;
        if (led_out !== 10'h2AA) begin
            n_fail++;
            $display("FAIL bypass_lat2: got %h expected %h", led_out, 10'h2AA);
        end
        @(negedge clk);
        n_checks++;
        if (settled !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_settled: got %b expected 1", settled);
        end
        pattern_in = 10'h155;
        @(negedge clk);
        n_checks++;
        if (led_out !== 10'h2AA) begin
            n_fail++;
            $display("FAIL bypass_chg1: got %h expected %h", led_out, 10'h2AA);
        end
        @(negedge clk);
        n_checks++;
        if (led_out !== 10'h155) begin
            n_fail++;
            $display("FAIL bypass_chg2: got %h expected %h", led_out, 10'h155);
        end
        repeat (3) @(negedge clk);
        bypass  = 1'b0;
        bad_led = 1'b0;
        bad_set = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (led_out !== 10'h155) bad_led = 1'b1;
            if (settled !== 1'b1) bad_set = 1'b1;
        end
        n_checks++;
        if (bad_led) begin
            n_fail++;
            $display("FAIL bypass_release_led: got glitch=1 expected glitch=0 (last %h)", led_out);
        end
        n_checks++;
        if (bad_set) begin
            n_fail++;
            $display("FAIL bypass_release_settled: got unsettled=1 expected unsettled=0");
        end
    endtask

    task automatic test_async_reset();
        int   cnt;
        logic s1, s2, stray;
        do_reset();
        sync_to(0);
        pattern_in = 10'h001;
        for (int lv = 0; lv < 7; lv++) begin
            run_period(0, cnt, s1, s2, stray);
        end
        // Level is 7 now; third sample uses pwm_cnt=1, so the LED is lit.
        repeat (3) @(negedge clk);
        n_checks++;
        if (led_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_lit: got %b expected 1", led_out[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (led_out !== 10'h000 || settled !== 1'b1) begin
            n_fail++;
            $display("FAIL async_immediate: got led=%h settled=%b expected led=000 settled=1",
                     led_out, settled);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sync_to(0);
        for (int lv = 0; lv < 3; lv++) begin
            run_period(0, cnt, s1, s2, stray);
            n_checks++;
            if (cnt != 2 * lv) begin
                n_fail++;
                $display("FAIL async_reramp_l%0d: got %0d expected %0d", lv, cnt, 2 * lv);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bypass     = 1'b0;
        pattern_in = 10'h000;
        @(negedge clk);
        test_reset();
        test_rise();
        test_hold_level5();
        test_fall();
        test_bypass();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
